// File: rtl/comparator_sched.sv
// Round-robin scheduler for two requesters sharing one bit-serial magnitude comparator.
// Streams operands LSB first, captures the {L,E,G} verdict and returns it with a done pulse.
module comparator_sched #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             done0,
    output logic             done1,
    output logic [2:0]       res0,
    output logic [2:0]       res1,
    output logic             busy,
    output logic             cmp_rst,
    output logic             cmp_op,
    output logic             cmp_a,
    output logic             cmp_b,
    input  logic             cmp_L,
    input  logic             cmp_E,
    input  logic             cmp_G
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_SHIFT,
        S_LAST,
        S_CAPT
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic             done0_q, done0_d, done1_q, done1_d;
    logic [2:0]       res0_q, res0_d, res1_q, res1_d;

    logic             elig0, elig1, grant1;
    logic [2:0]       verdict;

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        last_d  = last_q;
        res0_d  = res0_q;
        res1_d  = res1_q;
        done0_d = 1'b0;
        done1_d = 1'b0;
        // A req still high during its own done cycle is the old request, not a new one.
        elig0   = req0 & ~done0_q;
        elig1   = req1 & ~done1_q;
        grant1  = elig1 & (~elig0 | ~last_q);
        verdict = {cmp_L, cmp_E, cmp_G};

        case (state_q)
            S_IDLE: begin
                if (elig0 | elig1) begin
                    owner_d = grant1;
                    last_d  = grant1;
                    sa_d    = grant1 ? a1 : a0;
                    sb_d    = grant1 ? b1 : b0;
                    cnt_d   = '0;
                    state_d = S_CLR;
                end
            end
            S_CLR: state_d = S_SHIFT;
            S_SHIFT: begin
                sa_d = sa_q >> 1;
                sb_d = sb_q >> 1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_LAST;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_LAST: state_d = S_CAPT;
            S_CAPT: begin
                // A non-one-hot verdict is a comparator protocol fault, reported as 000.
                if (!$onehot(verdict)) verdict = 3'b000;
                if (owner_q) begin
                    res1_d  = verdict;
                    done1_d = 1'b1;
                end else begin
                    res0_d  = verdict;
                    done0_d = 1'b1;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            res0_q  <= 3'b010;
            res1_q  <= 3'b010;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            res0_q  <= res0_d;
            res1_q  <= res1_d;
        end
    end

    always_ff @(posedge clk) begin
        sa_q <= sa_d;
        sb_q <= sb_d;
    end

    assign done0   = done0_q;
    assign done1   = done1_q;
    assign res0    = res0_q;
    assign res1    = res1_q;
    assign busy    = (state_q != S_IDLE);
    assign cmp_rst = rst | (state_q == S_CLR);
    assign cmp_op  = ~rst & (state_q == S_LAST);
    assign cmp_a   = ~rst & ((state_q == S_SHIFT) | (state_q == S_LAST)) & sa_q[0];
    assign cmp_b   = ~rst & ((state_q == S_SHIFT) | (state_q == S_LAST)) & sb_q[0];

endmodule
